// File: rtl/clk_div_pkg.sv
// Shared constants for the clock-divider bank.
// Contents:
//   - the two output modes (toggle / pulse);
//   - default counter width and default divisor;
//   - a helper that sizes the channel-select field.
package clk_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int CNT_W_DEFAULT       = 16;
  localparam int DEFAULT_DIV_DEFAULT = 2499;

  // Width of a channel index; one bit minimum so a single-channel bank still has a port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Configuration bus of the clock-divider bank.
// Signals:
//   - cfg_we    : write strobe;
//   - cfg_ch    : target channel;
//   - cfg_div   : new divisor;
//   - cfg_mode  : new mode;
//   - cfg_ready : target channel can take a write.
// Modports:
//   - master : drives the request;
//   - slave  : the bank, which returns cfg_ready.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEFAULT
);
  localparam int CH_W = ch_width(NUM_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;
  logic             cfg_ready;

  modport master (output cfg_we, output cfg_ch, output cfg_div, output cfg_mode, input cfg_ready);
  modport slave  (input cfg_we, input cfg_ch, input cfg_div, input cfg_mode, output cfg_ready);

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/pending configuration and output logic.
// Ports:
//   - CLOCK, RESET : clock and synchronous active-high reset;
//   - en           : run enable;
//   - cfg_wr       : decoded write strobe for this channel;
//   - cfg_div      : divisor to stage;
//   - cfg_mode     : mode to stage;
//   - pend         : a staged configuration is waiting for a period boundary;
//   - tick         : registered one-cycle strobe on each wrap;
//   - slowclock    : registered toggle or pulse output.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             pend,
  output logic             tick,
  output logic             slowclock
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] div_act_r;
  logic [CNT_W-1:0] div_pend_r;
  logic             mode_act_r;
  logic             mode_pend_r;
  logic             pend_r;
  logic             tick_r;
  logic             slow_r;
  logic             wrap_s;

  // Period boundary: last count of the active divisor on a running channel.
  always_comb begin
    wrap_s = 1'b0;
    if (en && (count_r == div_act_r)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Counter, outputs and the active/pending configuration swap.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count_r     <= '0;
      div_act_r   <= CNT_W'(DEFAULT_DIV);
      div_pend_r  <= CNT_W'(DEFAULT_DIV);
      mode_act_r  <= MODE_TOGGLE;
      mode_pend_r <= MODE_TOGGLE;
      pend_r      <= 1'b0;
      tick_r      <= 1'b0;
      slow_r      <= 1'b0;
    end else begin
      if (!en) begin
        count_r <= '0;
        tick_r  <= 1'b0;
        slow_r  <= 1'b0;
      end else if (wrap_s) begin
        count_r <= '0;
        tick_r  <= 1'b1;
        // Output follows the mode in force during the period that just ended.
        slow_r  <= (mode_act_r == MODE_TOGGLE) ? ~slow_r : 1'b1;
      end else begin
        count_r <= count_r + CNT_W'(1);
        tick_r  <= 1'b0;
        slow_r  <= (mode_act_r == MODE_TOGGLE) ? slow_r : 1'b0;
      end

      // A stopped channel has no phase to protect, so staged config lands at once.
      if (pend_r && (wrap_s || !en)) begin
        div_act_r  <= div_pend_r;
        mode_act_r <= mode_pend_r;
        pend_r     <= 1'b0;
      end else if (cfg_wr && !pend_r) begin
        div_pend_r  <= cfg_div;
        mode_pend_r <= cfg_mode;
        pend_r      <= 1'b1;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

  assign pend      = pend_r;
  assign tick      = tick_r;
  assign slowclock = slow_r;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock-enable / slow-clock channels.
// Ports:
//   - CLOCK, RESET : clock and synchronous active-high reset;
//   - ch_en        : per-channel run enable;
//   - cfg          : configuration bus (slave side);
//   - tick         : per-channel one-cycle strobe per period;
//   - slowclock    : per-channel divided clock or pulse.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] ch_en,
  clk_div_bank_if.slave     cfg,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] slowclock
);

  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] pend_s;
  logic [NUM_CH-1:0] wr_s;
  logic              ready_s;

  // Ready mux and write decode; an index past the last channel matches nothing.
  always_comb begin
    ready_s = 1'b0;
    wr_s    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        ready_s = ~pend_s[i];
        wr_s[i] = cfg.cfg_we & ~pend_s[i];
      end else begin
        wr_s[i] = 1'b0;
      end
    end
  end

  assign cfg.cfg_ready = ready_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .en        (ch_en[g]),
      .cfg_wr    (wr_s[g]),
      .cfg_div   (cfg.cfg_div),
      .cfg_mode  (cfg.cfg_mode),
      .pend      (pend_s[g]),
      .tick      (tick[g]),
      .slowclock (slowclock[g])
    );
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock-enable and slow-clock generator. It is the parametrised successor of the single fixed-divisor divider. It provides NUM_CH independent channels, each with:
- a runtime-loadable divisor,
- a selectable output mode (50 % toggle or one-cycle pulse),
- a per-channel enable.

New divisors are applied glitch-free at period boundaries. It sits between the board CLOCK and the display, debounce and audio blocks that need slow ticks.

## Interface
Parameters:
- NUM_CH, 4, number of channels (≥1)
- CNT_W, 16, divisor/counter width
- DEFAULT_DIV, 2499, divisor loaded into every channel at reset (must fit CNT_W)

Ports:
- CLOCK  in  1  system clock; all logic on posedge
- RESET  in  1  synchronous, active-high reset
- ch_en  in  NUM_CH  per-channel run enable
- cfg_we  in  1  config write strobe
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_div  in  CNT_W  new divisor D
- cfg_mode  in  1  0 = toggle, 1 = pulse
- cfg_ready  out  1  combinational; high when channel cfg_ch has no pending config
- tick  out  NUM_CH  registered one-cycle strobe per period
- slowclock  out  NUM_CH  registered divided clock / pulse per mode

## Operation
Per-channel state:
- count[CNT_W]
- div_act, mode_act
- div_pend, mode_pend, pend flag
- slowclock, tick

Enabled channel (ch_en = 1):
- count increments each edge.
- When count == div_act, count returns to 0. This is a wrap.
- Period = div_act + 1 CLOCK cycles.
- On a wrap edge, tick is set to 1. On all other edges it is 0.
- Toggle mode: slowclock inverts on each wrap edge. Period is 2·(D+1) cycles, 50 % duty.
- Pulse mode: slowclock is set equal to the new tick value (one cycle high per period).
- D = 0: tick is high every cycle. Toggle mode gives CLOCK/2.

Disabled channel (ch_en = 0):
- count is held at 0; tick and slowclock are forced to 0.
- On re-enable, counting restarts from 0 with a fresh phase.

Config handshake:
- A write is accepted on the edge where cfg_we = 1 and cfg_ready = 1. It loads div_pend and mode_pend and sets pend.
- A write while cfg_ready = 0 is ignored with no side effect.
- A channel with pend set, on a wrap edge: div_act ← div_pend, mode_act ← mode_pend, pend cleared, count ← 0.
- The output update on that wrap edge uses the old mode_act.
- If the channel is disabled, a pending config is applied on the next edge.
- An out-of-range cfg_ch (NUM_CH not a power of 2) is ignored. cfg_ready reads 0 for it.

Boundary cases:
- A write accepted on the same edge as a wrap is not applied by that wrap. It takes effect at the next wrap.
- A switch from toggle to pulse with slowclock high: slowclock goes to 0 on the edge after the applying wrap, unless that edge is itself a wrap.
- RESET mid-operation: all channels return to reset state and pending configs are discarded.
- Channels never interact. Simultaneous wraps on several channels are independent.

## Timing
- Reset values: count = 0, div_act = DEFAULT_DIV, mode_act = toggle, pend = 0, tick = 0, slowclock = 0.
- cfg_ready is 1 after reset.
- Start-up: from reset release, or from enable rising with a config already active, the first tick is high after edge D+1. It stays high for exactly one cycle. The next tick follows after D+1 further edges.
- Latency:
  - From count == div_act being visible to tick/slowclock changing: 1 edge (the wrap edge).
  - Config: cfg_ready drops the cycle after acceptance. It returns to 1 the cycle after the applying wrap.
- No combinational path from inputs to tick or slowclock. cfg_ready depends combinationally on cfg_ch and pend only.

## Structure
- Package clk_div_pkg holds:
  - MODE_TOGGLE = 1'b0, MODE_PULSE = 1'b1
  - default CNT_W and DEFAULT_DIV constants
- Sub-module clk_div_ch: one channel (counter, active/pending registers, output logic).
- clk_div_bank generates NUM_CH instances. It decodes cfg_ch into per-channel write strobes and muxes pend into cfg_ready.

## Test plan
- Reset, channel 0 enabled, default D = 2499, toggle mode: tick high at edges 2500, 5000, 7500. slowclock rises at 2500 and falls at 5000.
- Write D = 2, pulse mode, to channel 1 while it runs at D = 2499: cfg_ready = 0 until the current period ends. Afterwards slowclock[1] = tick[1], high 1 of every 3 cycles.
- D = 0, toggle mode: tick constantly 1 and slowclock toggles every cycle. Second write while pending is ignored: the first value is applied and the second is lost.
- Write accepted on the exact wrap edge of channel 2 (D = 4 → 7): the next period is still 5 cycles, then periods are 8 cycles.
- Disable channel 3 mid-period with slowclock high: outputs go to 0 the next edge. Re-enable: first tick after D+1 edges.
- Assert RESET for 1 cycle with a config pending on channel 0 and count at 1200: all outputs 0, cfg_ready = 1, channel 0 back to D = 2499 with the pending config lost.
